// File: rtl/conv_decode_ctrl.sv
// Frame controller for a block-wise convolutional decoder: buffers coded symbol pairs,
// replays them to the decoder in 8-symbol bursts and hands out one decoded byte per burst.
module conv_decode_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CAP_DLY    = 2,
  parameter int BLK_SYMS   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic       sym_ready,
  output logic [1:0] dec_din,
  output logic       dec_reset,
  input  logic [7:0] dec_dout,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BLK_SYMS);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   BLK_C      = (AW+1)'(BLK_SYMS);
  localparam logic [BW-1:0] BURST_LAST = BW'(BLK_SYMS - 1);
  localparam logic [3:0]    WAIT_LAST  = 4'(CAP_DLY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    BURST = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [BW-1:0] burst_cnt;
  logic [3:0]    wait_cnt;
  logic [8:0]    bytes_left;
  logic          push, pop, xfer;

  // Both handshakes are plain valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the source holds valid and data steady until then.
  assign sym_ready = fifo_cnt < DEPTH_C;
  assign push      = sym_valid && sym_ready;
  assign pop       = (state == BURST);
  assign xfer      = (state == HOLD) && byte_valid && byte_ready;
  assign dec_din   = (state == BURST) ? mem[rd_ptr] : 2'b00;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (busy && fifo_cnt >= BLK_C && !byte_valid) state_next = CLR;
      CLR:     state_next = BURST;
      BURST:   if (burst_cnt == BURST_LAST) state_next = WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = HOLD;
      HOLD:    if (byte_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage carries no reset; discarding buffered symbols is done by clearing the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= sym_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      burst_cnt  <= '0;
      wait_cnt   <= '0;
      bytes_left <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      dec_reset  <= 1'b0;
    end else begin
      state      <= state_next;
      // Registered so the decoder leaves reset on the first clock after release.
      dec_reset  <= (state_next != CLR);
      frame_done <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - (AW+1)'(1);

      burst_cnt <= (state == BURST) ? burst_cnt + BW'(1) : '0;
      wait_cnt  <= (state == WAIT)  ? wait_cnt + 4'd1   : '0;

      if (state == IDLE && !busy && start) begin
        bytes_left <= (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
        busy       <= 1'b1;
      end

      if (state == WAIT && wait_cnt == WAIT_LAST) begin
        byte_data  <= dec_dout;
        byte_valid <= 1'b1;
      end

      if (xfer) begin
        byte_valid <= 1'b0;
        bytes_left <= bytes_left - 9'd1;
        if (bytes_left == 9'd1) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_decode_ctrl.sv
// Bench for conv_decode_ctrl: directed frames, a toy decoder model, a byte scoreboard
// fed at stimulus time and a negedge monitor that checks bytes and frame_done pulses.
module tb_conv_decode_ctrl;

  localparam int CAP_DLY = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] frame_len;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready;
  logic [1:0] dec_din;
  logic       dec_reset;
  logic [7:0] dec_dout;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       busy;
  logic       frame_done;
  logic [2:0] state_dbg;

  conv_decode_ctrl #(.FIFO_DEPTH(16), .CAP_DLY(CAP_DLY)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .dec_din(dec_din), .dec_reset(dec_reset), .dec_dout(dec_dout),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Toy decoder: after its reset, the first 8 symbols each yield one bit (sym[1]^sym[0]), MSB first.
  logic [7:0] dec_byte;
  logic [3:0] dec_cnt;
  always @(posedge clock) begin
    if (!dec_reset) begin
      dec_byte <= 8'h00;
      dec_cnt  <= 4'd0;
    end else if (dec_cnt < 4'd8) begin
      dec_byte <= {dec_byte[6:0], dec_din[1] ^ dec_din[0]};
      dec_cnt  <= dec_cnt + 4'd1;
    end
  end
  assign dec_dout = dec_byte;

  // scoreboard state
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  logic [1:0] sym_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // symbol driver
  int wr_cnt = 0;
  bit drv_hs;
  initial begin
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    forever begin
      @(negedge clock);
      drv_hs = reset && sym_valid && sym_ready;
      @(posedge clock);
      #1;
      if (drv_hs) begin
        void'(sym_q.pop_front());
        wr_cnt++;
      end
      if (sym_q.size() > 0) begin
        sym_valid = 1'b1;
        sym_data  = sym_q[0];
      end else begin
        sym_valid = 1'b0;
        sym_data  = 2'b00;
      end
    end
  end

  // output monitor
  int         cur_bytes = 0;
  int         n_xfer    = 0;
  int         n_frames  = 0;
  bit         done_due  = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clock) begin
    if (!reset) begin
      cur_bytes = 0;
      done_due  = 0;
      prev_hold = 0;
    end else begin
      if (done_due || frame_done) check("frame_done", frame_done, done_due);
      if (frame_done) n_frames++;
      done_due = 0;
      if (prev_hold) begin
        check("hold_valid", byte_valid, 1);
        check("hold_data", byte_data, prev_data);
      end
      if (!dec_reset) check("clr_while_byte_pending", byte_valid, 0);
      if (byte_valid && byte_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) check("unexpected_byte", byte_valid, 0);
        else check("byte_data", byte_data, exp_q.pop_front());
        cur_bytes++;
        if (exp_len_q.size() > 0 && cur_bytes == exp_len_q[0]) begin
          done_due  = 1;
          cur_bytes = 0;
          void'(exp_len_q.pop_front());
        end
      end
      prev_hold = byte_valid && !byte_ready;
      prev_data = byte_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic queue_syms(input logic [15:0] g, input int first, input int n);
    for (int i = first; i < first + n; i++) sym_q.push_back(g[15-2*i -: 2]);
  endtask

  task automatic queue_group(input logic [15:0] g, input logic [7:0] b);
    queue_syms(g, 0, 8);
    exp_q.push_back(b);
  endtask

  task automatic do_start(input logic [7:0] len, input bit accept);
    start     = 1'b1;
    frame_len = len;
    if (accept) exp_len_q.push_back((len == 8'd0) ? 256 : int'(len));
    tick();
    start     = 1'b0;
    frame_len = 8'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || sym_q.size() != 0 || exp_len_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, n < budget, 1);
    tick();
    tick();
  endtask

  task automatic wait_clr(input int budget);
    int n = 0;
    @(negedge clock);
    while (dec_reset && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("clr_seen", n < budget, 1);
  endtask

  // directed sequence
  int base, xfer0, frames0, n;
  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    frame_len  = 8'd0;
    byte_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sym_ready", sym_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_dec_din", dec_din, 2'b00);
    check("rst_dec_reset", dec_reset, 0);
    check("rst_state", state_dbg, 3'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("dec_reset_release", dec_reset, 1);

    // single byte of all-zero symbols, exact capture timing
    queue_group(16'h0000, 8'h00);
    do_start(8'd1, 1);
    check("busy_after_start", busy, 1);
    wait_clr(40);
    check("clr_dec_din", dec_din, 2'b00);
    check("clr_state", state_dbg, 3'd1);
    for (int k = 1; k <= CAP_DLY + 8; k++) begin
      @(negedge clock);
      if (k == 1) check("burst_dec_reset", dec_reset, 1);
    end
    check("no_byte_before_capture", byte_valid, 0);
    @(negedge clock);
    check("byte_after_capture", byte_valid, 1);
    tick();
    byte_ready = 1'b1;
    wait_done("t_single", 50);

    // three bytes with a long downstream stall on the first
    byte_ready = 1'b0;
    queue_group(16'h5555, 8'hFF);
    queue_group(16'h4444, 8'hAA);
    queue_group(16'hE1E1, 8'h55);
    do_start(8'd3, 1);
    n = 0;
    while (!byte_valid && n < 100) begin
      tick();
      n++;
    end
    check("first_byte_seen", n < 100, 1);
    repeat (20) tick();
    byte_ready = 1'b1;
    wait_done("t_stall", 200);

    // fill the FIFO while idle, then drain with a two-byte frame
    base = wr_cnt;
    queue_syms(16'hAA00, 0, 8);
    queue_syms(16'h0F93, 0, 8);
    queue_syms(16'h4001, 0, 4);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0C);
    n = 0;
    while (wr_cnt - base < 16 && n < 60) begin
      tick();
      n++;
    end
    check("fill_writes_seen", n < 60, 1);
    repeat (5) tick();
    @(negedge clock);
    check("sym_ready_full", sym_ready, 0);
    check("writes_when_full", wr_cnt - base, 16);
    check("busy_while_idle_fill", busy, 0);
    tick();
    do_start(8'd2, 1);
    wait_done("t_full", 200);
    check("sym_ready_after_drain", sym_ready, 1);
    check("writes_after_drain", wr_cnt - base, 20);

    // start while busy is ignored; leftover symbols complete this frame's byte
    frames0 = n_frames;
    exp_q.push_back(8'h81);
    do_start(8'd1, 1);
    do_start(8'd5, 0);
    queue_syms(16'h4001, 4, 4);
    wait_done("t_ignore", 100);
    check("busy_after_ignored_start", busy, 0);
    check("frames_ignore", n_frames - frames0, 1);

    // reset during burst cycle 4
    queue_group(16'h5555, 8'hFF);
    do_start(8'd1, 1);
    wait_clr(40);
    repeat (4) @(negedge clock);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    #1;
    check("abort_byte_valid", byte_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_frame_done", frame_done, 0);
    check("abort_byte_data", byte_data, 8'h00);
    check("abort_dec_din", dec_din, 2'b00);
    check("abort_dec_reset", dec_reset, 0);
    check("abort_sym_ready", sym_ready, 1);
    check("abort_state", state_dbg, 3'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("dec_reset_after_abort", dec_reset, 1);
    xfer0   = n_xfer;
    frames0 = n_frames;
    repeat (30) tick();
    check("no_byte_after_abort", n_xfer - xfer0, 0);
    check("no_done_after_abort", n_frames - frames0, 0);
    check("idle_after_abort", busy, 0);
    queue_group(16'h4001, 8'h81);
    do_start(8'd1, 1);
    wait_done("t_after_abort", 100);

    // frame_len 0 means 256 bytes
    for (int i = 0; i < 256; i++) begin
      if (i % 2 != 0) queue_group(16'h4444, 8'hAA);
      else queue_group(16'h5555, 8'hFF);
    end
    xfer0   = n_xfer;
    frames0 = n_frames;
    do_start(8'd0, 1);
    wait_done("t_256", 4000);
    check("bytes_256", n_xfer - xfer0, 256);
    check("frames_256", n_frames - frames0, 1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
